// File: rtl/raster_out.sv
// raster_out: display-side sink. A small FIFO absorbs the valid/ready pixel
// stream and a free-running raster generator drains it into rgb/de/hsync/vsync.
// Underflow or a misplaced end-of-frame marker drops into RESYNC, which keeps
// monitor timing alive while flushing to the next frame boundary.
module raster_out #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit SYNC_POL    = 1'b1,
  parameter int FIFO_DEPTH  = 16,
  parameter int FILL_THRESH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        clr_err,
  input  logic [23:0] in_pixel,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [23:0] rgb,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start,
  output logic        underflow,
  output logic        frame_err
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // one spare code so the exclusive sync-end bound always fits
  localparam int HW  = $clog2(H_TOT + 1);
  localparam int VW  = $clog2(V_TOT + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int AW1 = AW + 1;

  localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_ALAST = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST  = HW'(H_TOT - 1);
  localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_ALAST = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOT - 1);
  localparam logic [AW:0]   DEPTH_C  = AW1'(FIFO_DEPTH);
  localparam logic [AW:0]   THRESH_C = AW1'(FILL_THRESH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RUN, S_RESYNC} state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;

  // FIFO: word = {last, pixel}
  logic [24:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          in_ready_q, in_ready_d;
  logic          push, pop, empty;
  logic [24:0]   rd_word;

  logic          running, active, frame_wrap, end_px;
  logic          set_uf, set_fe, found_q, found_d;
  logic [23:0]   pix;

  logic [23:0]   rgb_q, rgb_d;
  logic          de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;
  logic          fs_q, fs_d, underflow_q, underflow_d, frame_err_q, frame_err_d;

  assign push    = in_valid & in_ready_q;
  assign empty   = (cnt_q == '0);
  assign rd_word = mem_q[rd_ptr_q];

  assign running    = (state_q == S_RUN) || (state_q == S_RESYNC);
  assign active     = running && (h_q < H_ACT) && (v_q < V_ACT);
  assign frame_wrap = (h_q == H_LAST) && (v_q == V_LAST);
  assign end_px     = (h_q == H_ALAST) && (v_q == V_ALAST);

  // FIFO pointer/occupancy update; ready is registered so it reflects post-edge fullness
  always_comb begin
    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    cnt_d      = cnt_q + AW1'(push) - AW1'(pop);
    in_ready_d = (cnt_d != DEPTH_C);
  end

  // FIFO storage, no reset needed: occupancy gates every read
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_last, in_pixel};
  end

  // raster counters: held at origin unless the timing is running
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (!running) begin
      h_d = '0;
      v_d = '0;
    end else if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end else begin
      h_d = h_q + 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; enable only matters at frame boundaries once running
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (enable) state_d = S_WAIT;
      S_WAIT:   if (!enable) state_d = S_IDLE;
                else if (cnt_q >= THRESH_C) state_d = S_RUN;
      S_RUN:    if (set_uf || set_fe) state_d = S_RESYNC;
                else if (frame_wrap && !enable) state_d = S_IDLE;
      S_RESYNC: if (frame_wrap && found_d) state_d = enable ? S_WAIT : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs: pop/error decisions and tracking of a discarded end-of-frame word.
  // An early last=1 word is itself the stream boundary, so it counts as found.
  always_comb begin
    pop     = 1'b0;
    set_uf  = 1'b0;
    set_fe  = 1'b0;
    pix     = '0;
    found_d = 1'b0;
    case (state_q)
      S_RUN: if (active) begin
        if (empty) begin
          set_uf = 1'b1;
        end else begin
          pop = 1'b1;
          pix = rd_word[23:0];
          if (rd_word[24] != end_px) begin
            set_fe  = 1'b1;
            found_d = rd_word[24];
          end
        end
      end
      S_RESYNC: begin
        found_d = found_q;
        if (!found_q && !empty) begin
          pop     = 1'b1;
          found_d = rd_word[24];
        end
      end
      default: ;
    endcase
  end

  // next values of the registered display outputs and sticky flags (new error beats clear)
  always_comb begin
    de_d        = active;
    rgb_d       = pix;
    hsync_d     = (running && h_q >= HS_BEG && h_q < HS_END) ? SYNC_POL : ~SYNC_POL;
    vsync_d     = (running && v_q >= VS_BEG && v_q < VS_END) ? SYNC_POL : ~SYNC_POL;
    fs_d        = active && (h_q == '0) && (v_q == '0);
    underflow_d = set_uf | (underflow_q & ~clr_err);
    frame_err_d = set_fe | (frame_err_q & ~clr_err);
  end

  // datapath, counter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q         <= '0;
      v_q         <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      found_q     <= 1'b0;
      rgb_q       <= '0;
      de_q        <= 1'b0;
      hsync_q     <= ~SYNC_POL;
      vsync_q     <= ~SYNC_POL;
      fs_q        <= 1'b0;
      underflow_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      h_q         <= h_d;
      v_q         <= v_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      found_q     <= found_d;
      rgb_q       <= rgb_d;
      de_q        <= de_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      fs_q        <= fs_d;
      underflow_q <= underflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign rgb         = rgb_q;
  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = fs_q;
  assign underflow   = underflow_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_raster_out.sv
// tb_raster_out: small-raster bench (14x7 totals, 8x4 active, 8-deep FIFO).
// A source process replays src_q with valid/ready; accepted pixels feed exp_q.
module tb_raster_out;
  logic        clk = 1'b0;
  logic        rst_n, enable, clr_err;
  logic [23:0] in_pixel, rgb;
  logic        in_valid, in_last, in_ready, de, hsync, vsync, frame_start, underflow, frame_err;

  int total = 0;
  int bad   = 0;
  logic [24:0] src_q[$];
  logic [23:0] exp_q[$];
  bit src_en = 1'b0, sb_on = 1'b0, hs_pending = 1'b0;

  raster_out #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b1), .FIFO_DEPTH(8), .FILL_THRESH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clr_err(clr_err),
    .in_pixel(in_pixel), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .rgb(rgb), .de(de), .hsync(hsync), .vsync(vsync), .frame_start(frame_start),
    .underflow(underflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // source: drives at negedge; a word presented with in_ready high is taken at the next posedge
  initial begin : src
    logic [24:0] w;
    in_valid = 1'b0; in_pixel = '0; in_last = 1'b0;
    forever begin
      @(negedge clk);
      if (hs_pending && src_q.size() > 0) begin
        w = src_q.pop_front();
        if (sb_on) exp_q.push_back(w[23:0]);
      end
      if (src_en && src_q.size() > 0) begin
        in_valid = 1'b1;
        {in_last, in_pixel} = src_q[0];
      end else begin
        in_valid = 1'b0;
      end
      hs_pending = in_valid && in_ready && rst_n;
    end
  end

  task automatic load_frame(input int n, input int last_at);
    logic l;
    for (int i = 0; i < n; i++) begin
      l = (i == last_at);
      src_q.push_back({l, 24'(i)});
    end
  endtask

  task automatic wait_fs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) ok = 1'b1;
    end
  endtask

  // samples one frame from the current frame_start negedge, counting de and ramp mismatches
  task automatic measure_ramp(output int de_n, output int err);
    de_n = 0; err = 0;
    for (int c = 0; c < 98; c++) begin
      if (c > 0) @(negedge clk);
      if (de === 1'b1) begin
        if (rgb !== 24'(de_n)) err++;
        de_n++;
      end else if (rgb !== 24'h0) err++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; clr_err = 1'b0;
    load_frame(1, 0); src_en = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    total++; if (de !== 1'b0) begin bad++; $display("FAIL rst_de: got %b want 0", de); end
    total++; if (hsync !== 1'b0) begin bad++; $display("FAIL rst_hsync: got %b want 0", hsync); end
    total++; if (vsync !== 1'b0) begin bad++; $display("FAIL rst_vsync: got %b want 0", vsync); end
    total++; if (rgb !== 24'h0) begin bad++; $display("FAIL rst_rgb: got %h want 0", rgb); end
    total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL rst_fs: got %b want 0", frame_start); end
    total++; if (underflow !== 1'b0) begin bad++; $display("FAIL rst_uf: got %b want 0", underflow); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL rst_fe: got %b want 0", frame_err); end
    rst_n = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rel_in_ready0: got %b want 0", in_ready); end
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rel_in_ready1: got %b want 1", in_ready); end
    #2;
    rst_n = 1'b0; enable = 1'b0; src_en = 1'b0; src_q.delete(); hs_pending = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ramp(input int nfr);
    bit ok;
    int de_n, fs_n, hs_e, vs_e, de_e, rgb_e, bh, bv;
    logic [23:0] ev;
    sb_on = 1'b1; exp_q.delete();
    for (int f = 0; f < nfr; f++) load_frame(32, 31);
    enable = 1'b1; src_en = 1'b1;
    wait_fs(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL ramp_start: frame_start seen=%b want 1", ok); end
    for (int f = 0; f < nfr; f++) begin
      de_n = 0; fs_n = 0; hs_e = 0; vs_e = 0; de_e = 0; rgb_e = 0;
      if (f == nfr - 1) enable = 1'b0;
      for (int c = 0; c < 98; c++) begin
        if (c > 0 || f > 0) @(negedge clk);
        bh = c % 14; bv = c / 14;
        if (frame_start === 1'b1) fs_n++;
        if (hsync !== (bh >= 10 && bh < 12)) hs_e++;
        if (vsync !== (bv == 5)) vs_e++;
        if (de !== (bh < 8 && bv < 4)) de_e++;
        if (de === 1'b1) begin
          de_n++;
          if (exp_q.size() == 0) rgb_e++;
          else begin ev = exp_q.pop_front(); if (rgb !== ev) rgb_e++; end
        end else if (rgb !== 24'h0) rgb_e++;
      end
      total++; if (de_n !== 32) begin bad++; $display("FAIL ramp_de_count f%0d: got %0d want 32", f, de_n); end
      total++; if (fs_n !== 1) begin bad++; $display("FAIL ramp_fs_count f%0d: got %0d want 1", f, fs_n); end
      total++; if (hs_e !== 0) begin bad++; $display("FAIL ramp_hsync f%0d: got %0d wrong cycles want 0", f, hs_e); end
      total++; if (vs_e !== 0) begin bad++; $display("FAIL ramp_vsync f%0d: got %0d wrong cycles want 0", f, vs_e); end
      total++; if (de_e !== 0) begin bad++; $display("FAIL ramp_de_pos f%0d: got %0d wrong cycles want 0", f, de_e); end
      total++; if (rgb_e !== 0) begin bad++; $display("FAIL ramp_rgb f%0d: got %0d wrong pixels want 0", f, rgb_e); end
    end
    repeat (3) @(negedge clk);
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL ramp_leftover: got %0d want 0", exp_q.size()); end
    total++; if (de !== 1'b0) begin bad++; $display("FAIL ramp_idle_de: got %b want 0", de); end
    sb_on = 1'b0; src_en = 1'b0;
  endtask

  task automatic test_underflow();
    bit ok, loaded;
    int k, rgb_e, de_n, err;
    load_frame(12, -1);
    enable = 1'b1; src_en = 1'b1;
    wait_fs(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL uf_start: frame_start seen=%b want 1", ok); end
    k = 0; rgb_e = 0; loaded = 1'b0;
    for (int c = 0; c < 98; c++) begin
      if (c > 0) @(negedge clk);
      if (de === 1'b1) begin
        if (k == 11) begin
          total++; if (underflow !== 1'b0) begin bad++; $display("FAIL uf_early: got %b want 0", underflow); end
        end
        if (k == 12) begin
          total++; if (underflow !== 1'b1) begin bad++; $display("FAIL uf_set: got %b want 1", underflow); end
        end
        if (k < 12) begin if (rgb !== 24'(k)) rgb_e++; end
        else if (rgb !== 24'h0) rgb_e++;
        k++;
        if (k > 12 && !loaded) begin load_frame(32, 31); load_frame(32, 31); loaded = 1'b1; end
      end
    end
    total++; if (rgb_e !== 0) begin bad++; $display("FAIL uf_rgb: got %0d wrong pixels want 0", rgb_e); end
    total++; if (k !== 32) begin bad++; $display("FAIL uf_de_count: got %0d want 32", k); end
    wait_fs(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL uf_relock: frame_start seen=%b want 1", ok); end
    enable = 1'b0;
    measure_ramp(de_n, err);
    total++; if (de_n !== 32) begin bad++; $display("FAIL uf_clean_de: got %0d want 32", de_n); end
    total++; if (err !== 0) begin bad++; $display("FAIL uf_clean_rgb: got %0d wrong want 0", err); end
    total++; if (underflow !== 1'b1) begin bad++; $display("FAIL uf_sticky: got %b want 1", underflow); end
    repeat (2) @(negedge clk);
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
    total++; if (underflow !== 1'b0) begin bad++; $display("FAIL uf_clear: got %b want 0", underflow); end
    src_en = 1'b0;
  endtask

  task automatic test_frame_err();
    bit ok;
    int k, rgb_e, de_n, err;
    load_frame(30, 29); load_frame(32, 31);
    enable = 1'b1; src_en = 1'b1;
    wait_fs(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL fe_start: frame_start seen=%b want 1", ok); end
    k = 0; rgb_e = 0;
    for (int c = 0; c < 98; c++) begin
      if (c > 0) @(negedge clk);
      if (de === 1'b1) begin
        if (k == 28) begin
          total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL fe_early: got %b want 0", frame_err); end
        end
        if (k == 29) begin
          total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL fe_set: got %b want 1", frame_err); end
        end
        if (k < 30) begin if (rgb !== 24'(k)) rgb_e++; end
        else if (rgb !== 24'h0) rgb_e++;
        k++;
      end
    end
    total++; if (rgb_e !== 0) begin bad++; $display("FAIL fe_rgb: got %0d wrong pixels want 0", rgb_e); end
    wait_fs(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL fe_relock: frame_start seen=%b want 1", ok); end
    enable = 1'b0;
    measure_ramp(de_n, err);
    total++; if (de_n !== 32) begin bad++; $display("FAIL fe_clean_de: got %0d want 32", de_n); end
    total++; if (err !== 0) begin bad++; $display("FAIL fe_clean_rgb: got %0d wrong want 0", err); end
    total++; if (underflow !== 1'b0) begin bad++; $display("FAIL fe_no_uf: got %b want 0", underflow); end
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL fe_clear: got %b want 0", frame_err); end
    src_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_backpressure();
    bit ok, stall;
    int de_n, rgb_e;
    logic [23:0] ev;
    sb_on = 1'b1; exp_q.delete();
    for (int f = 0; f < 3; f++) load_frame(32, 31);
    enable = 1'b1; src_en = 1'b1; stall = 1'b0;
    wait_fs(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL bp_start: frame_start seen=%b want 1", ok); end
    de_n = 0; rgb_e = 0;
    for (int f = 0; f < 3; f++) begin
      if (f == 2) enable = 1'b0;
      for (int c = 0; c < 98; c++) begin
        if (c > 0 || f > 0) @(negedge clk);
        if (in_valid === 1'b1 && in_ready === 1'b0) stall = 1'b1;
        if (de === 1'b1) begin
          de_n++;
          if (exp_q.size() == 0) rgb_e++;
          else begin ev = exp_q.pop_front(); if (rgb !== ev) rgb_e++; end
        end
      end
    end
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL bp_ready_drop: got %b want 1", stall); end
    total++; if (de_n !== 96) begin bad++; $display("FAIL bp_de_count: got %0d want 96", de_n); end
    total++; if (rgb_e !== 0) begin bad++; $display("FAIL bp_scoreboard: got %0d wrong want 0", rgb_e); end
    repeat (3) @(negedge clk);
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL bp_leftover: got %0d want 0", exp_q.size()); end
    sb_on = 1'b0; src_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int de_n, err;
    load_frame(32, 31); load_frame(32, 31);
    enable = 1'b1; src_en = 1'b1;
    wait_fs(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL mid_start: frame_start seen=%b want 1", ok); end
    repeat (3) @(negedge clk);
    total++; if (de !== 1'b1) begin bad++; $display("FAIL mid_pre_de: got %b want 1", de); end
    #2;
    rst_n = 1'b0; src_en = 1'b0; src_q.delete(); hs_pending = 1'b0;
    #1;
    total++; if (de !== 1'b0) begin bad++; $display("FAIL mid_de: got %b want 0", de); end
    total++; if (rgb !== 24'h0) begin bad++; $display("FAIL mid_rgb: got %h want 0", rgb); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_in_ready: got %b want 0", in_ready); end
    total++; if (hsync !== 1'b0 || vsync !== 1'b0) begin bad++; $display("FAIL mid_sync: got %b%b want 00", hsync, vsync); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    load_frame(32, 31); src_en = 1'b1;
    wait_fs(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL mid_restart: frame_start seen=%b want 1", ok); end
    enable = 1'b0;
    measure_ramp(de_n, err);
    total++; if (de_n !== 32) begin bad++; $display("FAIL mid_clean_de: got %0d want 32", de_n); end
    total++; if (err !== 0) begin bad++; $display("FAIL mid_clean_rgb: got %0d wrong want 0", err); end
    src_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; clr_err = 1'b0;
    test_reset();
    test_ramp(2);
    test_underflow();
    test_frame_err();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time=%0t limit=200000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
